// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding select codes and register-address width.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX operand: MEM result beats WB result,
// and register 0 is never forwarded.
module fwd_unit #(
    parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic             mem_en_rw,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_en_rw,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       fwd_sel
);
    import pipe_hazard_ctrl_pkg::*;

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    // Priority select of the youngest in-flight producer
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_en_rw && (mem_rd != REG_ZERO) && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_en_rw && (wb_rd != REG_ZERO) && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze with timeout fault,
// load-use stall, taken-branch flush, operand forwarding and stall statistics.
module pipe_hazard_ctrl #(
    parameter int REG_W   = pipe_hazard_ctrl_pkg::REG_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             ex_MReg,
    input  logic             ex_EnRW,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_EnRW,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_EnRW,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [15:0]      stall_cnt,
    output logic             fault
);
    import pipe_hazard_ctrl_pkg::*;

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d, wait_inc_s;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        fault_q, fault_d;
    logic        freeze_s, load_use_s, stall_s, timeout_s;
    logic [1:0]  fwd_a_s, fwd_b_s;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs(ex_rs1), .mem_en_rw(mem_EnRW), .mem_rd(mem_rd),
        .wb_en_rw(wb_EnRW), .wb_rd(wb_rd), .fwd_sel(fwd_a_s)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs(ex_rs2), .mem_en_rw(mem_EnRW), .mem_rd(mem_rd),
        .wb_en_rw(wb_EnRW), .wb_rd(wb_rd), .fwd_sel(fwd_b_s)
    );

    // Hazard detection; a branch flush already squashes the dependent instruction
    always_comb begin
        load_use_s = ex_MReg && ex_EnRW && (ex_rd != REG_ZERO) &&
                     ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
        freeze_s   = (mem_req && !dmem_ready) || (state_q == ST_FAULT);
        stall_s    = freeze_s || (load_use_s && !branch_taken);
        wait_inc_s = (state_q == ST_MEM_WAIT) ? (wait_cnt_q + 8'd1) : 8'd1;
        timeout_s  = (32'(wait_inc_s) >= TIMEOUT);
    end

    // Next-state logic: the first stalled cycle in RUN already counts as a wait cycle
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !dmem_ready) begin
                    wait_cnt_d = wait_inc_s;
                    if (timeout_s) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (timeout_s) begin
                    state_d    = ST_FAULT;
                    wait_cnt_d = wait_inc_s;
                    fault_d    = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc_s;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        stall_cnt_d = (stall_s && (stall_cnt_q != 16'hFFFF)) ? (stall_cnt_q + 16'd1) : stall_cnt_q;
    end

    // State, wait counter, stall statistics and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            fault_q     <= fault_d;
        end
    end

    // Pipeline control, zero latency; reset holds every stage frozen with NOPs
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
        fwd_a     = rst_n ? fwd_a_s : FWD_RF;
        fwd_b     = rst_n ? fwd_b_s : FWD_RF;
        stall_cnt = stall_cnt_q;
        fault     = fault_q;
    end

endmodule
